// File: rtl/tick_timer_pkg.sv
// Shared types and elaboration-time helpers for the tick timer arbiter.
//   state_t     : controller states IDLE / RUN / DONE
//   calc_limit  : clocks per tick derived from clock and tick rates, floored at 1
//   calc_width  : register width able to hold 0..n-1, floored at 1 bit
package tick_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_limit(input int clk_hz, input int tick_hz);
        int lim;
        lim = clk_hz / tick_hz;
        return (lim < 1) ? 1 : lim;
    endfunction

    function automatic int calc_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   i_req   : request vector
//   i_ptr   : index with highest priority this round
//   o_idx   : first set request at or after i_ptr, wrapping past N_REQ-1
//   o_valid : any request set
module rr_arbiter
    import tick_timer_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = calc_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan from the farthest offset down so the closest set bit to i_ptr wins
    always_comb begin
        int cand;
        cand    = 0;
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand  = (int'(i_ptr) + i) % N_REQ;
            o_idx = i_req[cand] ? IDX_W'(cand) : o_idx;
        end
    end

endmodule

// File: rtl/tick_timer_arbiter_chk.sv
// Property checker for the tick timer arbiter outputs and prescaler range.
//   grant/done : must be one-hot-or-zero and never overlap
//   tick/run   : a tick only ever appears while running
//   pre        : prescaler never exceeds LIMIT-1
module tick_timer_arbiter_chk #(
    parameter int N_REQ = 4,
    parameter int PRE_W = 1,
    parameter int LIMIT = 1
) (
    input logic             i_clk,
    input logic             i_rst_n,
    input logic [N_REQ-1:0] grant,
    input logic [N_REQ-1:0] done,
    input logic             tick,
    input logic             run,
    input logic [PRE_W-1:0] pre
);

    a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(grant));
    a_done_onehot:  assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(done));
    a_done_excl:    assert property (@(posedge i_clk) disable iff (!i_rst_n) !((|done) && (|grant)));
    a_tick_run:     assert property (@(posedge i_clk) disable iff (!i_rst_n) tick |-> run);
    a_pre_range:    assert property (@(posedge i_clk) disable iff (!i_rst_n) int'(pre) <= LIMIT - 1);

endmodule

// File: rtl/tick_timer_arbiter.sv
// Shares one tick prescaler among N_REQ requesters. A round-robin pick hands the
// timer to one requester, which waits its requested number of ticks and then gets
// a one-cycle done pulse. Dropping the request while running aborts silently.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_req          : level request per requester
//   i_ticks        : per-requester tick count, slice k at [k*CNT_W +: CNT_W]
//   o_grant        : current owner while running (one-hot or zero)
//   o_done         : completion pulse to the owner
//   o_busy         : running or completing
//   o_tick         : prescaler strobe while running
module tick_timer_arbiter
    import tick_timer_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int CLOCK_RATE_HZ = 100_000_000,
    parameter int TICK_RATE_HZ  = 1_000,
    parameter int CNT_W         = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*CNT_W-1:0] i_ticks,
    output logic [N_REQ-1:0]       o_grant,
    output logic [N_REQ-1:0]       o_done,
    output logic                   o_busy,
    output logic                   o_tick
);

    localparam int LIMIT = calc_limit(CLOCK_RATE_HZ, TICK_RATE_HZ);
    localparam int PRE_W = calc_width(LIMIT);
    localparam int IDX_W = calc_width(N_REQ);
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(LIMIT - 1);

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   owner_r, owner_s;
    logic [IDX_W-1:0]   ptr_r, ptr_s;
    logic [PRE_W-1:0]   pre_r, pre_s;
    logic [CNT_W-1:0]   rem_r, rem_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_valid_s;
    logic [IDX_W-1:0]   ptr_inc_s;
    logic [CNT_W-1:0]   req_ticks_s;
    logic [N_REQ-1:0]   owner_oh_s;
    logic               tick_s;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req   (i_req),
        .i_ptr   (ptr_r),
        .o_idx   (arb_idx_s),
        .o_valid (arb_valid_s)
    );

    assign req_ticks_s = i_ticks[int'(arb_idx_s) * CNT_W +: CNT_W];
    assign ptr_inc_s   = (int'(arb_idx_s) == N_REQ - 1) ? '0 : arb_idx_s + IDX_W'(1);
    assign owner_oh_s  = N_REQ'(1) << owner_r;
    // An abort in the same cycle as a prescaler expiry suppresses the strobe
    assign tick_s      = (state_r == RUN) && (pre_r == '0) && i_req[owner_r];

    // Controller, owner, round-robin pointer and counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            owner_r <= '0;
            ptr_r   <= '0;
            pre_r   <= '0;
            rem_r   <= '0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            pre_r   <= pre_s;
            rem_r   <= rem_s;
        end
    end

    // Next-state: grant from IDLE, count ticks in RUN, one-cycle DONE
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        ptr_s   = ptr_r;
        pre_s   = pre_r;
        rem_s   = rem_r;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    owner_s = arb_idx_s;
                    ptr_s   = ptr_inc_s;
                    pre_s   = PRE_RELOAD;
                    rem_s   = req_ticks_s;
                    state_s = (req_ticks_s == '0) ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!i_req[owner_r]) begin
                    state_s = IDLE;
                end else if (tick_s) begin
                    pre_s   = PRE_RELOAD;
                    // remaining is at least 1 here; the guard keeps it from wrapping
                    rem_s   = (rem_r >= CNT_W'(1)) ? rem_r - CNT_W'(1) : rem_r;
                    state_s = (rem_r <= CNT_W'(1)) ? DONE : RUN;
                end else begin
                    pre_s   = pre_r - PRE_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the registered state and owner
    always_comb begin
        o_grant = '0;
        o_done  = '0;
        o_busy  = 1'b0;
        o_tick  = tick_s;
        case (state_r)
            RUN: begin
                o_grant = owner_oh_s;
                o_busy  = 1'b1;
            end
            DONE: begin
                o_done = owner_oh_s;
                o_busy = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    tick_timer_arbiter_chk #(.N_REQ(N_REQ), .PRE_W(PRE_W), .LIMIT(LIMIT)) u_chk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .grant   (o_grant),
        .done    (o_done),
        .tick    (o_tick),
        .run     (state_r == RUN),
        .pre     (pre_r)
    );

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Bench for tick_timer_arbiter: vector table, directed multi-cycle sequences,
// a LIMIT=1 build, and random traffic against a timeline-based reference model.
module tb_tick_timer_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int L  = 10;

    typedef struct {
        logic [N-1:0]  req;
        logic [CW-1:0] ticks;
        int            req_until;
        int            chk;
        logic [N-1:0]  grant;
        logic [N-1:0]  done;
        logic          busy;
        logic          tick;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, grant, done;
    logic [N*CW-1:0] ticks;
    logic            busy, tick;
    logic [N-1:0]    req1, grant1, done1;
    logic [N*CW-1:0] ticks1;
    logic            busy1, tick1;

    int checks   = 0;
    int failures = 0;

    // reference model state: owner, start cycle, tick count, priority pointer
    bit m_act;
    int m_own, m_t0, m_k, m_ptr;

    always #5 clk = ~clk;

    tick_timer_arbiter #(.N_REQ(N), .CLOCK_RATE_HZ(10), .TICK_RATE_HZ(1), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_ticks(ticks),
        .o_grant(grant), .o_done(done), .o_busy(busy), .o_tick(tick));

    tick_timer_arbiter #(.N_REQ(N), .CLOCK_RATE_HZ(1), .TICK_RATE_HZ(1), .CNT_W(CW)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_ticks(ticks1),
        .o_grant(grant1), .o_done(done1), .o_busy(busy1), .o_tick(tick1));

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = '0;
        ticks  = '0;
        req1   = '0;
        ticks1 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs from the request timeline: granted at t0+1 .. t0+K*L,
    // ticks every L cycles, done at t0+K*L+1, dropped request aborts.
    task automatic model_step(input int c, output logic [N-1:0] eg, output logic [N-1:0] ed,
                              output logic eb, output logic et);
        int e;
        bit found;
        eg = '0; ed = '0; eb = 1'b0; et = 1'b0;
        found = 1'b0;
        if (m_act) begin
            e  = c - m_t0;
            eb = 1'b1;
            if (e > m_k * L) begin
                ed[m_own] = 1'b1;
                m_act     = 1'b0;
            end else begin
                eg[m_own] = 1'b1;
                if (!req[m_own]) m_act = 1'b0;
                else if (e % L == 0) et = 1'b1;
            end
        end else if (|req) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[(m_ptr + i) % N]) begin
                    found = 1'b1;
                    m_own = (m_ptr + i) % N;
                end
            end
            m_t0  = c;
            m_k   = int'(ticks[m_own*CW +: CW]);
            m_ptr = (m_own + 1) % N;
            m_act = 1'b1;
        end
    endtask

    initial begin
        vec_t vecs[15];
        logic [N-1:0] eg, ed, prev_done;
        logic eb, et;
        int ph, ow, ntick, nbad;

        //              req      ticks until chk grant    done     busy  tick
        vecs[0]  = '{4'b0001, 8'd3, 31,  0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{4'b0001, 8'd3, 31,  1, 4'b0001, 4'b0000, 1'b1, 1'b0};
        vecs[2]  = '{4'b0001, 8'd3, 31,  9, 4'b0001, 4'b0000, 1'b1, 1'b0};
        vecs[3]  = '{4'b0001, 8'd3, 31, 10, 4'b0001, 4'b0000, 1'b1, 1'b1};
        vecs[4]  = '{4'b0001, 8'd3, 31, 20, 4'b0001, 4'b0000, 1'b1, 1'b1};
        vecs[5]  = '{4'b0001, 8'd3, 31, 30, 4'b0001, 4'b0000, 1'b1, 1'b1};
        vecs[6]  = '{4'b0001, 8'd3, 31, 31, 4'b0000, 4'b0001, 1'b1, 1'b0};
        vecs[7]  = '{4'b0001, 8'd3, 31, 32, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[8]  = '{4'b0010, 8'd0,  1,  1, 4'b0000, 4'b0010, 1'b1, 1'b0};
        vecs[9]  = '{4'b0010, 8'd0,  1,  2, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{4'b1000, 8'd2, 21, 11, 4'b1000, 4'b0000, 1'b1, 1'b0};
        vecs[11] = '{4'b1000, 8'd2, 21, 21, 4'b0000, 4'b1000, 1'b1, 1'b0};
        vecs[12] = '{4'b0001, 8'd3,  5,  5, 4'b0001, 4'b0000, 1'b1, 1'b0};
        vecs[13] = '{4'b0001, 8'd3,  5,  6, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[14] = '{4'b0001, 8'd3,  5, 10, 4'b0000, 4'b0000, 1'b0, 1'b0};

        // reset values, both builds
        rst_n = 1'b0; req = '0; ticks = '0; req1 = '0; ticks1 = '0;
        #1;
        check("reset_main", 0, {grant, done, busy, tick}, 32'd0);
        check("reset_lim1", 0, {grant1, done1, busy1, tick1}, 32'd0);

        // vector table, each record from a fresh reset
        for (int r = 0; r < 15; r++) begin
            do_reset();
            for (int c = 0; c <= vecs[r].chk; c++) begin
                begin_cycle();
                req   = (c < vecs[r].req_until) ? vecs[r].req : '0;
                ticks = {N{vecs[r].ticks}};
                @(negedge clk);
                if (c == vecs[r].chk) begin
                    check($sformatf("vec%0d_grant", r), c, grant, vecs[r].grant);
                    check($sformatf("vec%0d_done", r),  c, done,  vecs[r].done);
                    check($sformatf("vec%0d_busy", r),  c, busy,  vecs[r].busy);
                    check($sformatf("vec%0d_tick", r),  c, tick,  vecs[r].tick);
                end
            end
        end

        // fairness: all four requesting with one tick each, 12-cycle slots
        do_reset();
        for (int c = 0; c <= 50; c++) begin
            begin_cycle();
            req   = 4'b1111;
            ticks = {N{8'd1}};
            @(negedge clk);
            eg = '0; ed = '0; et = 1'b0;
            if (c >= 1) begin
                ph = (c - 1) % 12;
                ow = ((c - 1) / 12) % N;
                if (ph < 10) eg[ow] = 1'b1;
                else if (ph == 10) ed[ow] = 1'b1;
                et = (ph == 9);
            end
            check("fair", c, {grant, done, tick}, {eg, ed, et});
        end

        // abort: owner 0 drops at 15, waiting requester 2 takes over at 17
        do_reset();
        for (int c = 0; c <= 37; c++) begin
            begin_cycle();
            req   = (c < 15) ? 4'b0101 : 4'b0100;
            ticks = {8'd0, 8'd2, 8'd0, 8'd5};
            @(negedge clk);
            if (c == 14) check("abort_pre", c, grant, 4'b0001);
            if (c == 16) check("abort_idle", c, {grant, done, busy, tick}, 32'd0);
            if (c == 17) check("abort_next_grant", c, grant, 4'b0100);
            if (c >= 11 && c <= 36) check("abort_no_done", c, done, 4'b0000);
            if (c == 20) check("abort_no_tick", c, tick, 1'b0);
            if (c == 26) check("abort_next_tick", c, tick, 1'b1);
            if (c == 37) check("abort_next_done", c, done, 4'b0100);
        end

        // asynchronous reset mid-run, then a full-latency restart
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            begin_cycle();
            req   = 4'b0001;
            ticks = {N{8'd3}};
            @(negedge clk);
            if (c == 12) check("rst_pre", c, {grant, busy}, {4'b0001, 1'b1});
        end
        rst_n = 1'b0;
        #1;
        check("rst_async", 12, {grant, done, busy, tick}, 32'd0);
        do_reset();
        for (int c = 0; c <= 31; c++) begin
            begin_cycle();
            req   = (c < 31) ? 4'b0001 : 4'b0000;
            ticks = {N{8'd3}};
            @(negedge clk);
            if (c == 1)  check("rst_restart_grant", c, grant, 4'b0001);
            if (c == 10) check("rst_restart_tick", c, tick, 1'b1);
            if (c == 31) check("rst_restart_done", c, done, 4'b0001);
        end

        // LIMIT=1 build with the largest count
        do_reset();
        ntick = 0;
        nbad  = 0;
        for (int c = 0; c <= 257; c++) begin
            begin_cycle();
            req1   = (c < 256) ? 4'b0001 : 4'b0000;
            ticks1 = {N{8'd255}};
            @(negedge clk);
            if (tick1) begin
                if (c >= 1 && c <= 255) ntick++;
                else nbad++;
            end
            if (c == 255) check("lim1_grant", c, grant1, 4'b0001);
            if (c == 256) check("lim1_done", c, done1, 4'b0001);
            if (c == 257) check("lim1_idle", c, {grant1, done1, busy1}, 32'd0);
        end
        check("lim1_tick_count", 257, ntick, 255);
        check("lim1_stray_ticks", 257, nbad, 0);

        // random traffic against the reference model
        do_reset();
        m_act = 1'b0; m_own = 0; m_t0 = 0; m_k = 0; m_ptr = 0;
        prev_done = '0;
        for (int c = 0; c < 3000; c++) begin
            begin_cycle();
            for (int k = 0; k < N; k++) begin
                if (!req[k]) req[k] = ($urandom_range(0, 3) == 0);
                else if (prev_done[k]) req[k] = ($urandom_range(0, 1) == 0);
                else if ($urandom_range(0, 63) == 0) req[k] = 1'b0;
                ticks[k*CW +: CW] = CW'($urandom_range(0, 3));
            end
            @(negedge clk);
            model_step(c, eg, ed, eb, et);
            check("rand", c, {grant, done, busy, tick}, {eg, ed, eb, et});
            prev_done = ed;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
